// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
// Sends one DATA_BITS-wide word per accepted request, LSB first. The frame has
// an optional parity bit (even, odd or mark) and 1 or 2 stop bits. Every bit
// lasts exactly CLKS_PER_BIT clock cycles.
// Optional feature: define UART_TX_BREAK_EN to add the break_req input and the
// line-break states BREAK and MAB (mark-after-break).
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_ready,
  input  logic [DATA_BITS-1:0] byte_trans,
  input  logic [1:0]           parity_mode,
  output logic                 tx_ready,
  output logic                 trans_active,
  output logic                 data_out,
  output logic                 done_sig
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                 break_req
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK,
    S_MAB
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 par_en_q, par_en_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 brk_w;
  logic                 par_calc;
  logic                 cnt_last;

`ifdef UART_TX_BREAK_EN
  assign brk_w = break_req;
`else
  assign brk_w = 1'b0;
`endif

  assign cnt_last = (cnt_q == CNT_LAST);

  // Parity of the incoming word, resolved at accept time so the shifting data
  // register does not need to be re-examined later.
  always_comb begin
    par_calc = 1'b0;
    case (parity_mode)
      2'b01:   par_calc = ^byte_trans;
      2'b10:   par_calc = ~(^byte_trans);
      2'b11:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  // Handshake and activity flags are decoded straight from the state register.
  always_comb begin
    tx_ready     = (state_q == S_IDLE) && !rst && !brk_w;
    trans_active = (state_q != S_IDLE) && !rst;
`ifdef UART_TX_BREAK_EN
    if (state_q == S_MAB) trans_active = 1'b0;
`endif
  end

  // Next-state logic; tx_d is the line level for the cycle after the edge, so
  // data_out is registered yet lines up exactly with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    data_d   = data_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    tx_d     = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (brk_w) begin
`ifdef UART_TX_BREAK_EN
          state_d = S_BREAK;
          tx_d    = 1'b0;
`endif
        end else if (data_ready) begin
          data_d   = byte_trans;
          par_d    = par_calc;
          par_en_d = (parity_mode != 2'b00);
          cnt_d    = '0;
          bit_d    = '0;
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = data_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        tx_d = data_q[0];
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d  = bit_q + BW'(1);
            data_d = data_q >> 1;
            tx_d   = data_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (cnt_last) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        tx_d = 1'b0;
        if (!brk_w) begin
          cnt_d   = '0;
          state_d = S_MAB;
          tx_d    = 1'b1;
        end
      end
      S_MAB: begin
        tx_d = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign data_out = tx_q;
  assign done_sig = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: three instances (8N1, 8x2, 7x1) at CLKS_PER_BIT=4.
// Each accepted word pushes its expected per-cycle line image into a queue;
// a negedge monitor per instance pops and compares every cycle.
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic dr0, dr1, dr2;
  logic [7:0] bt0, bt1;
  logic [6:0] bt2;
  logic [1:0] pm0, pm1, pm2;
  logic br0, br1, br2;
  logic rdy0, rdy1, rdy2;
  logic act0, act1, act2;
  logic out0, out1, out2;
  logic done0, done1, done2;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // entry layout: {tx_ready, done_sig, trans_active, data_out}
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [3:0] e0, e1, e2;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .data_ready(dr0), .byte_trans(bt0), .parity_mode(pm0),
    .tx_ready(rdy0), .trans_active(act0), .data_out(out0), .done_sig(done0)
`ifdef UART_TX_BREAK_EN
    , .break_req(br0)
`endif
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .data_ready(dr1), .byte_trans(bt1), .parity_mode(pm1),
    .tx_ready(rdy1), .trans_active(act1), .data_out(out1), .done_sig(done1)
`ifdef UART_TX_BREAK_EN
    , .break_req(br1)
`endif
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .data_ready(dr2), .byte_trans(bt2), .parity_mode(pm2),
    .tx_ready(rdy2), .trans_active(act2), .data_out(out2), .done_sig(done2)
`ifdef UART_TX_BREAK_EN
    , .break_req(br2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_e(input int d, input logic [3:0] e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits,
  // each held CPB cycles, then the one-cycle done/ready pulse.
  task automatic push_frame(input int d, input logic [8:0] data, input logic [1:0] mode);
    int dbits = (d == 2) ? 7 : 8;
    int sbits = (d == 1) ? 2 : 1;
    logic p = 1'b0;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < dbits; i++) begin
      bits.push_back(data[i]);
      p = p ^ data[i];
    end
    case (mode)
      2'b01: bits.push_back(p);
      2'b10: bits.push_back(~p);
      2'b11: bits.push_back(1'b1);
      default: ;
    endcase
    for (int i = 0; i < sbits; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < CPB; c++) push_e(d, {3'b001, bits[i]});
    push_e(d, 4'b1101);
  endtask

  task automatic drive(input int d, input logic req, input logic [8:0] data, input logic [1:0] mode);
    case (d)
      0: begin dr0 = req; bt0 = data[7:0]; pm0 = mode; end
      1: begin dr1 = req; bt1 = data[7:0]; pm1 = mode; end
      default: begin dr2 = req; bt2 = data[6:0]; pm2 = mode; end
    endcase
  endtask

  // Called at posedge+1; request is accepted on the next edge.
  task automatic send(input int d, input logic [8:0] data, input logic [1:0] mode);
    drive(d, 1'b1, data, mode);
    @(posedge clk); #1;
    push_frame(d, data, mode);
    drive(d, 1'b0, data, mode);
    $display("TX dut=%0d data=0x%0h mode=%b at %0t", d, data, mode, $time);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(n < 500), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      e0 = (q0.size() > 0) ? q0.pop_front() : 4'b1001;
      check("dut0_line", 32'({rdy0, done0, act0, out0}), 32'(e0));
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      e1 = (q1.size() > 0) ? q1.pop_front() : 4'b1001;
      check("dut1_line", 32'({rdy1, done1, act1, out1}), 32'(e1));
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      e2 = (q2.size() > 0) ? q2.pop_front() : 4'b1001;
      check("dut2_line", 32'({rdy2, done2, act2, out2}), 32'(e2));
    end
  end

  initial begin
    rst = 1'b1;
    dr0 = 0; dr1 = 0; dr2 = 0;
    bt0 = '0; bt1 = '0; bt2 = '0;
    pm0 = '0; pm1 = '0; pm2 = '0;
    br0 = 0; br1 = 0; br2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'({out0, out1, out2}), 32'h7);
    check("rst_active", 32'({act0, act1, act2}), 32'h0);
    check("rst_done", 32'({done0, done1, done2}), 32'h0);
    check("rst_tx_ready", 32'({rdy0, rdy1, rdy2}), 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'({rdy0, rdy1, rdy2}), 32'h7);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 8N1, 8E2, 7-bit odd/mark, plus a few extra patterns
    send(0, 9'h0A5, 2'b00);
    send(1, 9'h0A5, 2'b01);
    send(2, 9'h041, 2'b10);
    drain();
    send(2, 9'h041, 2'b11);
    send(1, 9'h03C, 2'b10);
    send(0, 9'h0E7, 2'b01);
    drain();
    send(1, 9'h081, 2'b11);
    send(2, 9'h07F, 2'b01);
    drain();

    // back-to-back with data_ready held high
    drive(0, 1'b1, 9'h000, 2'b00);
    @(posedge clk); #1;
    push_frame(0, 9'h000, 2'b00);
    $display("TX dut=0 data=0x0 mode=00 b2b first at %0t", $time);
    drive(0, 1'b1, 9'h0FF, 2'b00);
    repeat (41) @(posedge clk);
    #1;
    push_frame(0, 9'h0FF, 2'b00);
    drive(0, 1'b0, 9'h0FF, 2'b00);
    $display("TX dut=0 data=0xff mode=00 b2b second at %0t", $time);
    drain();

    // reset in the middle of a frame
    send(0, 9'h0C3, 2'b01);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    check("abort_data_out", 32'(out0), 32'd1);
    check("abort_done", 32'(done0), 32'd0);
    rst = 1'b0;
    $display("RST mid-frame dut=0 at %0t", $time);
    repeat (4) @(posedge clk);
    #1;
    send(0, 9'h055, 2'b00);
    drain();

`ifdef UART_TX_BREAK_EN
    // line break in idle: 20 cycles low, 4 cycles mark-after-break
    br0 = 1'b1;
    push_e(0, 4'b0001);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) push_e(0, 4'b0010);
    for (int i = 0; i < 4; i++) push_e(0, 4'b0001);
    repeat (19) @(posedge clk);
    #1;
    br0 = 1'b0;
    $display("BREAK dut=0 20 cycles at %0t", $time);
    drain();
    // break request during a frame leaves it untouched
    send(0, 9'h096, 2'b10);
    repeat (8) @(posedge clk);
    #1;
    br0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    br0 = 1'b0;
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
